// File: rtl/ripple_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ripple_add_sequencer  (+ helper ripple_adder)
//  Purpose  : Multi-cycle wide adder. Drives one 4-bit ripple adder with one
//             operand nibble per cycle, LSB nibble first. The nibble carry-out
//             is registered and fed back as the next nibble's carry-in. The
//             sum nibbles are collected, and the full-width result is
//             presented with a one-cycle done pulse.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             start     - request an add; accepted only while busy=0
//             a_in      - operand A (W = 4*NIBBLES bits), captured on accept
//             b_in      - operand B, captured on accept
//             cin_in    - carry into nibble 0, captured on accept
//             busy      - high while nibbles are being added
//             done      - one-cycle pulse, new sum_out/cout_out valid
//             sum_out   - full sum, held until the next done
//             cout_out  - final carry, held until the next done
//             ovf_out   - signed overflow (only with SEQ_OVERFLOW_EN)
//  Config   : `define SEQ_OVERFLOW_EN adds the ovf_out port and its logic
//  Revision : 1.0 - initial release
// ============================================================================

module ripple_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[4];

endmodule

module ripple_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 cin_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum_out,
  output logic                 cout_out
`ifdef SEQ_OVERFLOW_EN
  ,
  output logic                 ovf_out
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;        // operand A, shifted right one nibble per cycle
  logic [W-1:0]    r_b;        // operand B, shifted right one nibble per cycle
  logic            r_carry;    // carry into the current nibble
  logic [CW-1:0]   r_cnt;      // nibble index k
  logic [W-1:0]    r_sum;      // partial sum, nibbles enter at the top
`ifdef SEQ_OVERFLOW_EN
  logic            r_a_msb;    // sign bits kept from the latched operands
  logic            r_b_msb;
`endif

  logic [3:0]      w_nib_sum;
  logic            w_nib_cout;
  logic [W-1:0]    w_sum_next;
  logic            w_last;
  logic            w_accept;

  ripple_adder u_adder (
    .i_a    (r_a[3:0]),
    .i_b    (r_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // After NIBBLES insertions at the top the first nibble lands at bit 0.
  assign w_sum_next = (r_sum >> 4) | (W'(w_nib_sum) << (W - 4));
  assign w_last     = (r_cnt == CW'(NIBBLES - 1));
  assign w_accept   = start && (r_state != S_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
`ifdef SEQ_OVERFLOW_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      ovf_out  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_state <= S_BUSY;
            busy    <= 1'b1;
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin_in;
            r_cnt   <= '0;
            r_sum   <= '0;
`ifdef SEQ_OVERFLOW_EN
            r_a_msb <= a_in[W-1];
            r_b_msb <= b_in[W-1];
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_carry <= w_nib_cout;
          r_sum   <= w_sum_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            sum_out  <= w_sum_next;
            cout_out <= w_nib_cout;
`ifdef SEQ_OVERFLOW_EN
            // Sum MSB is bit 3 of the final nibble being stored this edge.
            ovf_out  <= (r_a_msb == r_b_msb) && (w_nib_sum[3] != r_a_msb);
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ripple_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ripple_add_sequencer
//  Purpose  : Self-checking bench for ripple_add_sequencer (NIBBLES=4).
//             Directed cases followed by random operands, compared against
//             plain arithmetic A+B+cin.
//  Config   : honours SEQ_OVERFLOW_EN for the ovf_out port
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ripple_add_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SEQ_OVERFLOW_EN
  logic         ovf_out;
  logic         exp_ovf = 1'b0;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;

  logic [W-1:0] ra, rb, na, nb;
  logic         rc, nc;
  bit           pre, ch;

  always #5 clk = ~clk;

  ripple_add_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef SEQ_OVERFLOW_EN
    ,
    .ovf_out  (ovf_out)
`endif
  );

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    chkw({tag, "_sum"}, sum_out, exp_sum);
    chk1({tag, "_cout"}, cout_out, exp_cout);
`ifdef SEQ_OVERFLOW_EN
    chk1({tag, "_ovf"}, ovf_out, exp_ovf);
`endif
  endtask

  // One operation. pre=1: start was already driven in the previous done
  // cycle. chain=1: drive the next operation's start in this done cycle.
  // ign=1: pulse a stray start with other operands while busy.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit ign, input bit chain,
                        input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input bit preissued);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    if (!preissued) begin
      start = 1'b1; a_in = a; b_in = b; cin_in = c;
    end
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
    for (int i = 0; i < NIBBLES; i++) begin
      chk1("busy_during_op", busy, 1'b1);
      chk1("no_early_done", done, 1'b0);
      check_held("held_during_op");
      if (ign && i == 1) begin
        start = 1'b1; a_in = {(W/4){4'hA}}; b_in = {(W/4){4'h5}}; cin_in = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
`ifdef SEQ_OVERFLOW_EN
    exp_ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`endif
    chk1("done_pulse", done, 1'b1);
    chk1("busy_in_done", busy, 1'b0);
    check_held("result");
    if (chain) begin
      start = 1'b1; a_in = xa; b_in = xb; cin_in = xc;
    end else begin
      @(negedge clk);
      chk1("done_one_cycle", done, 1'b0);
      chk1("idle_not_busy", busy, 1'b0);
      check_held("result_held");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    repeat (2) @(negedge clk);
    // start together with rst must be dropped
    start = 1'b1; a_in = 16'h1111; b_in = 16'h1111;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);
    check_held("reset");
    @(negedge clk);
    chk1("rst_wins_busy", busy, 1'b0);

    // Directed cases
    run_op(16'h1234, 16'h4321, 1'b0, 0, 0, '0, '0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, 0, '0, '0, 1'b0, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1, 0, '0, '0, 1'b0, 0);
    run_op(16'h1111, 16'h2222, 1'b0, 0, 1, 16'h8000, 16'h8000, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0, 0, '0, '0, 1'b0, 1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0, '0, '0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0, '0, '0, 1'b0, 0);

    // Reset during BUSY cycle k=2, with start also raised
    start = 1'b1; a_in = 16'h5555; b_in = 16'h5555; cin_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
`ifdef SEQ_OVERFLOW_EN
    exp_ovf = 1'b0;
`endif
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    check_held("abort");
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(negedge clk);
      chk1("abort_no_done", done, 1'b0);
      chk1("abort_stays_idle", busy, 1'b0);
    end

    // Random operations, some issued back-to-back from DONE
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    pre = 1'b0;
    for (int i = 0; i < 24; i++) begin
      na = W'($urandom); nb = W'($urandom); nc = 1'($urandom);
      if (i % 6 == 5) na = '1;
      ch = (i < 23) && ($urandom_range(0, 1) == 1);
      run_op(ra, rb, rc, 0, ch, na, nb, nc, pre);
      pre = ch;
      ra = na; rb = nb; rc = nc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
